// File: rtl/helper_axis_pkg.sv
// Shared types for the AXIS bench helpers: drain modes, drain FSM states
// and the 16-bit Galois LFSR step used for random back-pressure.
package helper_axis_pkg;

  typedef enum logic [1:0] {
    ALWAYS = 2'd0,
    DUTY   = 2'd1,
    RANDOM = 2'd2
  } drain_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } drain_state_t;

  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_step(
    input logic [15:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR16_TAPS)
                : (s >> 1);
  endfunction

endpackage

// File: rtl/helper_ready_gen.sv
// Registered gate pattern: always-on, ON/OFF duty cycle or LFSR random.
// Ports: clk, rst (async, high), advance (step pattern) -> gate_q.
module helper_ready_gen
  import helper_axis_pkg::*;
#(
  parameter int          MODE         = 0,
  parameter int          ON_CYCLES    = 4,
  parameter int          OFF_CYCLES   = 2,
  parameter int          READY_THRESH = 128,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic gate_q
);

  localparam drain_mode_t MD = drain_mode_t'(MODE);
  localparam int PERIOD = ON_CYCLES + OFF_CYCLES;
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_n;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_n;

  // gate is a pure function of the pattern state it is registered with
  function automatic logic gate_of(
    input logic [PW-1:0] p,
    input logic [7:0]    s
  );
    logic g;
    g = 1'b1;
    unique case (1'b1)
      (MD == DUTY):
        g = (OFF_CYCLES == 0) ||
            (32'(p) < 32'(ON_CYCLES));
      (MD == RANDOM):
        g = {1'b0, s} < 9'(READY_THRESH);
      default:
        g = 1'b1;
    endcase
    return g;
  endfunction

  always_comb begin
    phase_n = phase_q;
    lfsr_n  = lfsr_q;
    if (advance) begin
      phase_n = (32'(phase_q) == 32'(PERIOD - 1))
              ? '0 : phase_q + 1'b1;
      lfsr_n  = lfsr16_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      lfsr_q  <= LFSR_SEED;
      gate_q  <= gate_of('0, LFSR_SEED[7:0]);
    end else begin
      phase_q <= phase_n;
      lfsr_q  <= lfsr_n;
      gate_q  <= gate_of(phase_n, lfsr_n[7:0]);
    end
  end

endmodule

// File: rtl/helper_axis_drain_pattern.sv
// AXIS sink with patterned ready, beat/packet counters and done flag.
// Ports: clk, rst, enable, input_valid/data/last -> input_ready,
// beats_consumed, packets_consumed, done, data_error, error_count.
// HELPER_AXIS_DRAIN_CHECK_EN adds the incrementing payload check.
module helper_axis_drain_pattern
  import helper_axis_pkg::*;
#(
  parameter int          DATA_WIDTH     = 10,
  parameter int          COUNT_WIDTH    = 32,
  parameter int          MODE           = 0,
  parameter int          ON_CYCLES      = 4,
  parameter int          OFF_CYCLES     = 2,
  parameter int          READY_THRESH   = 128,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          EXPECTED_BEATS = 0,
  parameter int          CHECK_START    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   input_valid,
  input  logic [DATA_WIDTH-1:0]  input_data,
  input  logic                   input_last,
  output logic                   input_ready,
  output logic [COUNT_WIDTH-1:0] beats_consumed,
  output logic [COUNT_WIDTH-1:0] packets_consumed,
  output logic                   done,
  output logic                   data_error,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;
  // a target beyond the counter range can never be reached
  localparam bit EB_OK = (EXPECTED_BEATS > 0) &&
    (longint'(EXPECTED_BEATS) <=
     ((64'd1 << COUNT_WIDTH) - 64'd1));

  drain_state_t           state_q;
  drain_state_t           state_n;
  logic                   gate_q;
  logic                   advance;
  logic                   hs;
  logic [COUNT_WIDTH-1:0] beats_q;
  logic [COUNT_WIDTH-1:0] beats_n;
  logic [COUNT_WIDTH-1:0] pkts_q;

  assign advance     = enable & (state_q == ACTIVE);
  assign input_ready = advance & gate_q;
  assign hs          = input_valid & input_ready;
  assign beats_n     = (beats_q == CMAX)
                     ? beats_q : beats_q + 1'b1;

  helper_ready_gen #(
    .MODE         (MODE),
    .ON_CYCLES    (ON_CYCLES),
    .OFF_CYCLES   (OFF_CYCLES),
    .READY_THRESH (READY_THRESH),
    .LFSR_SEED    (LFSR_SEED)
  ) u_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .gate_q  (gate_q)
  );

  always_comb begin
    state_n = state_q;
    unique case (1'b1)
      (state_q == IDLE):
        if (enable) state_n = ACTIVE;
      (state_q == ACTIVE):
        if (hs && EB_OK &&
            beats_n == COUNT_WIDTH'(EXPECTED_BEATS))
          state_n = DONE;
      default:
        state_n = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q <= '0;
      pkts_q  <= '0;
    end else if (hs) begin
      beats_q <= beats_n;
      if (input_last && pkts_q != CMAX)
        pkts_q <= pkts_q + 1'b1;
    end
  end

  assign beats_consumed   = beats_q;
  assign packets_consumed = pkts_q;
  assign done             = (state_q == DONE);

`ifdef HELPER_AXIS_DRAIN_CHECK_EN
  logic [DATA_WIDTH-1:0]  exp_q;
  logic [COUNT_WIDTH-1:0] err_q;
  logic                   derr_q;

  // reference advances on every accepted beat, match or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q  <= DATA_WIDTH'(CHECK_START);
      err_q  <= '0;
      derr_q <= 1'b0;
    end else if (hs) begin
      exp_q <= exp_q + 1'b1;
      if (input_data != exp_q) begin
        derr_q <= 1'b1;
        if (err_q != CMAX) err_q <= err_q + 1'b1;
      end
    end
  end

  assign data_error  = derr_q;
  assign error_count = err_q;
`else
  logic unused_data;
  assign unused_data = (^input_data) ^ (CHECK_START != 0);
  assign data_error  = 1'b0;
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_helper_axis_drain_pattern.sv
// Bench for helper_axis_drain_pattern: seven configurations run side by
// side against a queue-free arithmetic model of the drain rules.
module tb_helper_axis_drain_pattern;

  localparam int N = 7;
  localparam int P_MODE[N] = '{0, 1, 2, 2, 2, 0, 0};
  localparam int P_ON[N]   = '{4, 3, 4, 4, 4, 4, 4};
  localparam int P_OFF[N]  = '{2, 2, 2, 2, 2, 2, 2};
  localparam int P_TH[N]   = '{128, 128, 0, 256, 128, 128, 128};
  localparam int P_EB[N]   = '{8, 0, 0, 8, 0, 0, 4};
  localparam int P_CS[N]   = '{0, 0, 0, 0, 0, 0, 5};
  localparam int P_CW[N]   = '{32, 32, 32, 32, 32, 3, 32};

`ifdef HELPER_AXIS_DRAIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en[N];
  logic        vld[N];
  logic        lst[N];
  logic [9:0]  dat[N];
  logic        rdy[N];
  logic        dn[N];
  logic        de[N];
  logic [31:0] bc[N];
  logic [31:0] pc[N];
  logic [31:0] ec[N];

  for (genvar g = 0; g < N; g++) begin : gi
    if (g == 5) begin : nar
      logic [2:0] b, p, e;
      helper_axis_drain_pattern #(
        .DATA_WIDTH(10), .COUNT_WIDTH(3),
        .MODE(P_MODE[g]), .ON_CYCLES(P_ON[g]),
        .OFF_CYCLES(P_OFF[g]), .READY_THRESH(P_TH[g]),
        .LFSR_SEED(16'hACE1), .EXPECTED_BEATS(P_EB[g]),
        .CHECK_START(P_CS[g])
      ) u (
        .clk(clk), .rst(rst), .enable(en[g]),
        .input_valid(vld[g]), .input_data(dat[g]),
        .input_last(lst[g]), .input_ready(rdy[g]),
        .beats_consumed(b), .packets_consumed(p),
        .done(dn[g]), .data_error(de[g]), .error_count(e)
      );
      assign bc[g] = {29'd0, b};
      assign pc[g] = {29'd0, p};
      assign ec[g] = {29'd0, e};
    end else begin : wid
      helper_axis_drain_pattern #(
        .DATA_WIDTH(10), .COUNT_WIDTH(32),
        .MODE(P_MODE[g]), .ON_CYCLES(P_ON[g]),
        .OFF_CYCLES(P_OFF[g]), .READY_THRESH(P_TH[g]),
        .LFSR_SEED(16'hACE1), .EXPECTED_BEATS(P_EB[g]),
        .CHECK_START(P_CS[g])
      ) u (
        .clk(clk), .rst(rst), .enable(en[g]),
        .input_valid(vld[g]), .input_data(dat[g]),
        .input_last(lst[g]), .input_ready(rdy[g]),
        .beats_consumed(bc[g]), .packets_consumed(pc[g]),
        .done(dn[g]), .data_error(de[g]), .error_count(ec[g])
      );
    end
  end

  // model state: 0 idle, 1 active, 2 done; k = pattern advances
  int          m_st[N];
  longint      m_k[N];
  logic [15:0] m_lfsr[N];
  longint      m_bc[N], m_pc[N], m_ec[N];
  bit          m_de[N];
  int          m_exp[N];
  int          m_acc[N];

  int n_chk = 0;
  int n_pass = 0;

  function automatic longint cmax(input int i);
    return (P_CW[i] >= 32) ? 64'hFFFF_FFFF
                           : (64'd1 << P_CW[i]) - 1;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic bit m_gate(input int i);
    if (P_MODE[i] == 1)
      return (P_OFF[i] == 0) ||
             ((m_k[i] % (P_ON[i] + P_OFF[i])) < P_ON[i]);
    if (P_MODE[i] == 2)
      return int'(m_lfsr[i][7:0]) < P_TH[i];
    return 1'b1;
  endfunction

  function automatic bit m_ready(input int i);
    return en[i] && m_st[i] == 1 && m_gate(i);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_k[i] = 0; m_lfsr[i] = 16'hACE1;
      m_bc[i] = 0; m_pc[i] = 0; m_ec[i] = 0;
      m_de[i] = 0; m_exp[i] = P_CS[i]; m_acc[i] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else begin
      for (int i = 0; i < N; i++) begin
        bit r;
        r = m_ready(i);
        if (m_st[i] == 0) begin
          if (en[i]) m_st[i] = 1;
        end else if (m_st[i] == 1) begin
          if (en[i]) begin
            m_k[i]++;
            m_lfsr[i] = lstep(m_lfsr[i]);
          end
          if (vld[i] && r) begin
            m_acc[i]++;
            if (m_bc[i] < cmax(i)) m_bc[i]++;
            if (lst[i] && m_pc[i] < cmax(i)) m_pc[i]++;
            if (CHK && int'(dat[i]) != m_exp[i]) begin
              m_de[i] = 1;
              if (m_ec[i] < cmax(i)) m_ec[i]++;
            end
            m_exp[i] = (m_exp[i] + 1) % 1024;
            if (P_EB[i] != 0 && m_bc[i] == P_EB[i])
              m_st[i] = 2;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d] got %0d want %0d @%0t",
                  nm, i, act, exp, $time);
  endtask

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      chk("ready", i, rdy[i], m_ready(i));
      chk("beats", i, bc[i], m_bc[i]);
      chk("packets", i, pc[i], m_pc[i]);
      chk("done", i, dn[i], m_st[i] == 2);
      chk("data_error", i, de[i], m_de[i]);
      chk("error_count", i, ec[i], m_ec[i]);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  int tbl[4] = '{5, 6, 9, 8};
  int pat[5] = '{1, 1, 1, 0, 0};

  initial begin
    rst = 1'b1;
    m_reset();
    for (int i = 0; i < N; i++) begin
      en[i] = 0; vld[i] = 0; lst[i] = 0; dat[i] = '0;
    end
    repeat (2) cyc();
    for (int i = 0; i < N; i++) begin
      chk("rst_ready", i, rdy[i], 0);
      chk("rst_beats", i, bc[i], 0);
      chk("rst_done", i, dn[i], 0);
    end
    rst = 1'b0;

    for (int c = 0; c <= 20; c++) begin
      cyc();
      if (c >= 1 && c <= 5)
        chk("duty_pat", 1, rdy[1], pat[c-1]);
      if (c == 1) chk("lfsr_seed_rdy", 4, rdy[4], 0);
      if (c == 2) begin
        chk("lfsr_step1", 4, m_lfsr[4], 16'hE270);
        chk("lfsr_step1_rdy", 4, rdy[4], 1);
      end
      if (c == 3) chk("lfsr_step2", 4, m_lfsr[4], 16'h7138);
      for (int i = 0; i < N; i++) begin
        en[i] = 1; vld[i] = 1; lst[i] = 0;
        dat[i] = 10'($urandom);
      end
      dat[0] = 10'(m_acc[0]);
      dat[3] = 10'(m_acc[3]);
      vld[5] = m_acc[5] < 10;
      lst[5] = (m_acc[5] % 2) == 1;
      dat[6] = (m_acc[6] < 4) ? 10'(tbl[m_acc[6]]) : 10'd0;
    end
    cyc();
    chk("t1_beats", 0, bc[0], 8);
    chk("t1_done", 0, dn[0], 1);
    chk("t1_ready_after", 0, rdy[0], 0);
    chk("t2_beats", 1, bc[1], 12);
    chk("t3_never", 2, bc[2], 0);
    chk("t3_always", 3, bc[3], 8);
    chk("t6_sat", 5, bc[5], 7);
    chk("t6_pkts", 5, pc[5], 5);
    chk("t5_errs", 6, ec[6], CHK ? 1 : 0);
    chk("t5_sticky", 6, de[6], CHK ? 1 : 0);

    for (int c = 0; c < 5; c++) begin
      en[1] = 0;
      #1 chk("t4_ready_off", 1, rdy[1], 0);
      cyc();
    end
    en[1] = 1;
    repeat (10) cyc();

    for (int i = 0; i < N; i++) begin
      en[i] = 1; vld[i] = 1;
    end
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("midrst_ready", i, rdy[i], 0);
      chk("midrst_beats", i, bc[i], 0);
      chk("midrst_done", i, dn[i], 0);
    end
    cyc();
    rst = 1'b0;

    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        en[i]  = $urandom_range(0, 7) != 0;
        vld[i] = $urandom_range(0, 3) != 0;
        lst[i] = $urandom_range(0, 2) == 0;
        dat[i] = 10'($urandom);
      end
      if ($urandom_range(0, 3) != 0) dat[6] = 10'(m_exp[6]);
    end
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
